mod_enc_key_expansion: RTL and testbench

MOD_ENC_KEY_EXPANSION -- requirements
Module: mod_enc_key_expansion

---
 rtl/mod_enc_key_expansion_pkg.sv | 39 +++
 rtl/mod_enc_key_expansion_if.sv | 21 ++
 rtl/mod_enc_key_expansion_sub_word.sv | 13 +
 rtl/mod_enc_key_expansion.sv | 117 +++++++++++
 tb/tb_mod_enc_key_expansion.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mod_enc_key_expansion_pkg.sv
// rtl/mod_enc_key_expansion_pkg.sv - shared AES-256 key schedule constants, S-box and FSM state type
package enc_pkg;

  localparam int NK = 8;
  localparam int NR = 14;

  // Entry 0 is never used: word index 8 maps to Rcon[1].
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY0 = 3'd1,
    ST_KEY1 = 3'd2,
    ST_GEN  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/mod_enc_key_expansion_if.sv
// rtl/mod_enc_key_expansion_if.sv - key schedule request / round-key stream interface
interface mod_enc_key_expansion_if;
  logic         start;
  logic [255:0] key;
  logic         rk_ready;
  logic [127:0] rk;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, key, rk_ready,
    input  rk, rk_valid, rk_idx, busy, done
  );

  modport slave (
    input  start, key, rk_ready,
    output rk, rk_valid, rk_idx, busy, done
  );
endinterface

// File: rtl/mod_enc_key_expansion_sub_word.sv
// rtl/mod_enc_key_expansion_sub_word.sv - combinational SubWord, four S-box lookups
module mod_enc_sub_word
  import enc_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
  end

endmodule

// File: rtl/mod_enc_key_expansion.sv
// rtl/mod_enc_key_expansion.sv - AES-256 key schedule, one word per cycle over an 8-word window
module mod_enc_key_expansion
  import enc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  mod_enc_key_expansion_if.slave  bus
);

  state_t        state_q;
  logic [31:0]   win_q [NK];
  logic [127:0]  rk_q;
  logic          rk_valid_q;
  logic [3:0]    rk_idx_q;
  logic          busy_q;
  logic          done_q;
  logic [5:0]    word_i_q;
  logic [1:0]    gen_cnt_q;

  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   new_word;

  // win_q[7] is w[i-1] and win_q[0] is w[i-8] for the word being produced.
  always_comb begin
    sub_in   = word_i_q[2] ? win_q[7] : {win_q[7][7:0], win_q[7][31:8]};
    temp     = win_q[7];
    if (word_i_q[2:0] == 3'd0) begin
      temp = sub_out ^ {24'h0, RCON[word_i_q[5:3]]};
    end else if (word_i_q[2:0] == 3'd4) begin
      temp = sub_out;
    end
    new_word = win_q[0] ^ temp;
  end

  mod_enc_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_i_q   <= '0;
      gen_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (bus.start && !done_q) begin
            for (int k = 0; k < NK; k++) win_q[k] <= bus.key[32*k +: 32];
            rk_q       <= bus.key[127:0];
            rk_idx_q   <= 4'd0;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            word_i_q   <= 6'd8;
            state_q    <= ST_KEY0;
          end
        end
        ST_KEY0: begin
          if (bus.rk_ready) begin
            rk_q     <= {win_q[7], win_q[6], win_q[5], win_q[4]};
            rk_idx_q <= 4'd1;
            state_q  <= ST_KEY1;
          end
        end
        ST_KEY1: begin
          if (bus.rk_ready) begin
            rk_valid_q <= 1'b0;
            gen_cnt_q  <= 2'd0;
            state_q    <= ST_GEN;
          end
        end
        ST_GEN: begin
          for (int k = 0; k < NK - 1; k++) win_q[k] <= win_q[k+1];
          win_q[NK-1] <= new_word;
          word_i_q    <= word_i_q + 6'd1;
          gen_cnt_q   <= gen_cnt_q + 2'd1;
          if (gen_cnt_q == 2'd3) begin
            rk_q       <= {new_word, win_q[7], win_q[6], win_q[5]};
            rk_idx_q   <= rk_idx_q + 4'd1;
            rk_valid_q <= 1'b1;
            state_q    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.rk_ready) begin
            rk_valid_q <= 1'b0;
            if (rk_idx_q == 4'(NR)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_GEN;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rk       = rk_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_idx   = rk_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mod_enc_key_expansion.sv
// tb/tb_mod_enc_key_expansion.sv - scoreboard bench for the AES-256 key schedule
module tb_mod_enc_key_expansion;
  import enc_pkg::*;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    logic [127:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mod_enc_key_expansion_if bus();

  mod_enc_key_expansion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  logic [255:0] key_a;
  logic [255:0] key_fips;
  logic [127:0] hand_rk0, hand_rk1, hand_rk2, hand_rk14;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [255:0] rev_bytes(input logic [255:0] v, input int n);
    logic [255:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = v[8*(n-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[x[8*b +: 8]];
    return r;
  endfunction

  // Straight FIPS-197 expansion into a full 60-word array.
  function automatic logic [127:0] model_rk(input logic [255:0] k, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sub_w({t[7:0], t[31:8]});
        t[7:0] = t[7:0] ^ (8'h01 << (i/8 - 1));
      end else if (i % 8 == 4) begin
        t = sub_w(t);
      end
      w[i] = w[i-8] ^ t;
    end
    return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endfunction

  task automatic push_all(input logic [255:0] k, input int sel);
    exp_t e;
    for (int r = 0; r <= 14; r++) begin
      e.idx  = 4'(r);
      e.data = model_rk(k, r);
      e.mask = '1;
      if (sel == 1) begin
        if (r == 0)  e.data = hand_rk0;
        if (r == 1)  e.data = hand_rk1;
        if (r == 2)  e.data = hand_rk2;
        if (r == 14) e.data = hand_rk14;
      end else if (sel == 2 && r == 14) begin
        e.data = {32'h1e636c70, 96'h0};
        e.mask = {32'hffffffff, 96'h0};
      end
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done) done_cnt++;
    if (rst_n && bus.rk_valid && bus.rk_ready) begin
      chk("sb_has_entry", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk($sformatf("rk_idx_%0d", e.idx), bus.rk_idx, e.idx);
        chk($sformatf("rk_%0d", e.idx), bus.rk & e.mask, e.data & e.mask);
      end
    end
  end

  task automatic wait_idx(input int i);
    bit found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_idx == 4'(i)) found = 1;
    end
    chk($sformatf("wait_idx_%0d", i), found, 1);
  endtask

  task automatic run_full(input string tag, input logic [255:0] k, input int sel);
    int c0;
    int d0;
    bit seen = 0;
    push_all(k, sel);
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.key = k; bus.start = 1'b1; bus.rk_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c0 = cyc;
    @(negedge clk);
    chk({tag, "_rk0_latency"}, {bus.rk_valid, bus.rk_idx, bus.busy}, {1'b1, 4'd0, 1'b1});
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_total_cycles"}, cyc - c0, 67);
    chk({tag, "_busy_low_at_done"}, bus.busy, 0);
    // start during the done cycle must be dropped
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_start_at_done_ignored"}, {bus.rk_valid, bus.busy}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp5;
    for (int j = 0; j < 32; j++) key_a[8*j +: 8] = 8'(j);
    key_fips  = rev_bytes(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32);
    hand_rk0  = 128'(rev_bytes(256'h000102030405060708090a0b0c0d0e0f, 16));
    hand_rk1  = 128'(rev_bytes(256'h101112131415161718191a1b1c1d1e1f, 16));
    hand_rk2  = 128'(rev_bytes(256'ha573c29fa176c498a97fce93a572c09c, 16));
    hand_rk14 = 128'(rev_bytes(256'h24fc79ccbf0979e9371ac23c6d68de36, 16));

    bus.start = 1'b0; bus.key = '0; bus.rk_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.rk, bus.rk_idx, bus.rk_valid, bus.busy, bus.done}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_reset", {bus.rk, bus.rk_idx, bus.rk_valid, bus.busy, bus.done}, '0);

    run_full("seq_key", key_a, 1);
    run_full("fips_a3", key_fips, 2);

    // stall at idx 5, stray start at idx 7, reset at idx 9
    exp5 = model_rk(key_a, 5);
    push_all(key_a, 1);
    @(posedge clk); #1;
    bus.key = key_a; bus.start = 1'b1; bus.rk_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idx(4);
    @(posedge clk); #1;
    bus.rk_ready = 1'b0;
    wait_idx(5);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_hold_%0d", i), {bus.rk, bus.rk_idx, bus.rk_valid}, {exp5, 4'd5, 1'b1});
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rk_ready = 1'b1;
    wait_idx(7);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key = ~key_a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_stray_start", bus.busy, 1);
    wait_idx(9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.rk, bus.rk_idx, bus.rk_valid, bus.busy, bus.done}, '0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("quiet_after_reset_%0d", i), {bus.rk, bus.rk_idx, bus.rk_valid, bus.busy, bus.done}, '0);
    end

    run_full("restart", key_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
